butterfly_driver: RTL and testbench

Host-side sequencer for the radix-2 butterfly datapath. It accepts one butterfly job (twiddle index, A, B) on a valid/ready port and serialises it onto the butterfly's 8-bit operand bus. It then deserialises the four result bytes (Re Y, Im Y, Re Z, Im Z) and presents them as one packed result on a valid/ready port. It sits between the FFT stage scheduler and the butterfly core, one instance per core.

---
 rtl/butterfly_pkg.sv | 24 ++
 rtl/bfly_collect.sv | 45 ++++
 rtl/butterfly_driver.sv | 174 +++++++++++++++++
 tb/tb_butterfly_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// Shared types for the butterfly host-side sequencer.
package butterfly_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND_W,
    SEND_B,
    SEND_A,
    WAIT,
    COLLECT,
    OUT
  } bfly_drv_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] y_re;
    logic [DATA_W-1:0] y_im;
    logic [DATA_W-1:0] z_re;
    logic [DATA_W-1:0] z_im;
    logic              err;
  } bfly_result_t;

endpackage

// File: rtl/bfly_collect.sv
// Four-slot result byte deserialiser: slot counter, synchronous clear, done on the last byte.
module bfly_collect
  import butterfly_pkg::*;
(
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   clear_i,
  input  logic                   store_i,
  input  logic [DATA_W-1:0]      byte_i,
  output logic [3:0][DATA_W-1:0] slots_o,
  output logic                   done_o
);

  logic [1:0]             k_q, k_d;
  logic [3:0][DATA_W-1:0] slot_q, slot_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    k_d    = k_q;
    slot_d = slot_q;
    if (clear_i) begin
      k_d    = '0;
      slot_d = '0;
    end else if (store_i) begin
      slot_d[k_q] = byte_i;
      k_d         = k_q + 2'd1;
    end
  end

  // NOTE: the slots drive outputs directly, so they are reset like control state rather than left as uninitialised storage.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      k_q    <= '0;
      slot_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops sample the same pre-edge values.
      k_q    <= k_d;
      slot_q <= slot_d;
    end
  end

  assign slots_o = slot_q;
  assign done_o  = store_i && !clear_i && (k_q == 2'd3);

endmodule

// File: rtl/butterfly_driver.sv
// Job serialiser / result deserialiser for one radix-2 butterfly core.
// Optional result timeout compiled in with BUTTERFLY_DRIVER_TIMEOUT_EN.
module butterfly_driver
  import butterfly_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int IDX_W          = 3
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [IDX_W-1:0]  job_index,
  input  logic [DATA_W-1:0] job_a,
  input  logic [DATA_W-1:0] job_b,
  output logic [DATA_W-1:0] bfly_data,
  output logic              bfly_go,
  input  logic [DATA_W-1:0] bfly_result,
  input  logic              bfly_rvalid,
  output logic              bfly_abort,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_y_re,
  output logic [DATA_W-1:0] res_y_im,
  output logic [DATA_W-1:0] res_z_re,
  output logic [DATA_W-1:0] res_z_im,
  output logic              res_err,
  output logic [15:0]       job_count
);

  bfly_drv_state_t        state_q, state_d;
  logic [DATA_W-1:0]      a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   go_q, go_d;
  logic                   abort_q, abort_d;
  logic                   res_valid_q, res_valid_d;
  logic                   err_q, err_d;
  logic [15:0]            count_q, count_d;

  logic                   job_hs, res_hs, collecting, store, done, timeout;
  logic [3:0][DATA_W-1:0] slots;
  bfly_result_t           res;

  assign job_ready  = (state_q == IDLE);
  assign job_hs     = job_valid && job_ready;
  assign res_hs     = res_valid_q && res_ready;
  assign collecting = (state_q == WAIT) || (state_q == COLLECT);
  assign store      = collecting && bfly_rvalid;

  bfly_collect u_collect (
    .Clock   (Clock),
    .nReset  (nReset),
    .clear_i (job_hs),
    .store_i (store),
    .byte_i  (bfly_result),
    .slots_o (slots),
    .done_o  (done)
  );

`ifdef BUTTERFLY_DRIVER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts idle cycles since entering WAIT or since the last stored byte.
  always_comb begin
    cnt_d = '0;
    if (collecting && !store) cnt_d = cnt_q + CNT_W'(1);
  end

  assign timeout = collecting && !store && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Outputs are computed for the state being entered so they appear registered in that state.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = '0;
    go_d        = 1'b0;
    abort_d     = 1'b0;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: begin
        if (job_hs) begin
          a_d     = job_a;
          b_d     = job_b;
          data_d  = DATA_W'(job_index);
          go_d    = 1'b1;
          state_d = SEND_W;
        end
      end
      SEND_W: begin
        data_d  = b_q;
        state_d = SEND_B;
      end
      SEND_B: begin
        data_d  = a_q;
        state_d = SEND_A;
      end
      SEND_A: state_d = WAIT;
      WAIT, COLLECT: begin
        if (done) begin
          res_valid_d = 1'b1;
          state_d     = OUT;
        end else if (timeout) begin
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          abort_d     = 1'b1;
          state_d     = OUT;
        end else if (store) begin
          state_d = COLLECT;
        end
      end
      OUT: begin
        if (res_hs) begin
          res_valid_d = 1'b0;
          err_d       = 1'b0;
          count_d     = count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      go_q        <= 1'b0;
      abort_q     <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      go_q        <= go_d;
      abort_q     <= abort_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign res = '{y_re: slots[0], y_im: slots[1], z_re: slots[2], z_im: slots[3], err: err_q};

  assign bfly_data  = data_q;
  assign bfly_go    = go_q;
  assign bfly_abort = abort_q;
  assign res_valid  = res_valid_q;
  assign res_y_re   = res.y_re;
  assign res_y_im   = res.y_im;
  assign res_z_re   = res.z_re;
  assign res_z_im   = res.z_im;
  assign res_err    = res.err;
  assign job_count  = count_q;

endmodule

// File: tb/tb_butterfly_driver.sv
// Directed self-checking bench for butterfly_driver; timeout steps run when BUTTERFLY_DRIVER_TIMEOUT_EN is defined.
module tb_butterfly_driver;

  localparam int IDX_W = 3;

  logic             Clock = 1'b0;
  logic             nReset;
  logic             job_valid;
  logic             job_ready;
  logic [IDX_W-1:0] job_index;
  logic [7:0]       job_a, job_b;
  logic [7:0]       bfly_data;
  logic             bfly_go;
  logic [7:0]       bfly_result;
  logic             bfly_rvalid;
  logic             bfly_abort;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_y_re, res_y_im, res_z_re, res_z_im;
  logic             res_err;
  logic [15:0]      job_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] gap_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 Clock = ~Clock;

  butterfly_driver #(.TIMEOUT_CYCLES(8), .IDX_W(IDX_W)) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_index   (job_index),
    .job_a       (job_a),
    .job_b       (job_b),
    .bfly_data   (bfly_data),
    .bfly_go     (bfly_go),
    .bfly_result (bfly_result),
    .bfly_rvalid (bfly_rvalid),
    .bfly_abort  (bfly_abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_y_re    (res_y_re),
    .res_y_im    (res_y_im),
    .res_z_re    (res_z_re),
    .res_z_im    (res_z_im),
    .res_err     (res_err),
    .job_count   (job_count)
  );

  task automatic check_b(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [7:0] yr, input logic [7:0] yi,
                              input logic [7:0] zr, input logic [7:0] zi, input logic err);
    check_b({tag, "_y_re"}, res_y_re, yr);
    check_b({tag, "_y_im"}, res_y_im, yi);
    check_b({tag, "_z_re"}, res_z_re, zr);
    check_b({tag, "_z_im"}, res_z_im, zi);
    check_bit({tag, "_err"}, res_err, err);
  endtask

  task automatic check_quiet(input string tag, input logic [15:0] count);
    check_bit({tag, "_job_ready"}, job_ready, 1'b1);
    check_b({tag, "_bfly_data"}, bfly_data, 8'h00);
    check_bit({tag, "_bfly_go"}, bfly_go, 1'b0);
    check_bit({tag, "_bfly_abort"}, bfly_abort, 1'b0);
    check_bit({tag, "_res_valid"}, res_valid, 1'b0);
    check_w({tag, "_job_count"}, job_count, count);
  endtask

  // Accepts a job and checks the three operand bytes; returns in the first WAIT cycle.
  task automatic send_job(input string tag, input logic [IDX_W-1:0] idx,
                          input logic [7:0] a, input logic [7:0] b, input bit stray);
    logic [7:0] w;
    w = 8'(idx);
    job_valid = 1'b1;
    job_index = idx;
    job_a     = a;
    job_b     = b;
    if (stray) begin
      bfly_rvalid = 1'b1;
      bfly_result = 8'hAA;
    end
    check_bit({tag, "_accept_ready"}, job_ready, 1'b1);
    tick();
    job_valid   = 1'b0;
    job_index   = '0;
    job_a       = '0;
    job_b       = '0;
    bfly_rvalid = 1'b0;
    check_bit({tag, "_busy_ready"}, job_ready, 1'b0);
    check_b({tag, "_data_w"}, bfly_data, w);
    check_bit({tag, "_go_w"}, bfly_go, 1'b1);
    tick();
    if (stray) begin
      bfly_rvalid = 1'b1;
      bfly_result = 8'hAA;
    end
    check_b({tag, "_data_b"}, bfly_data, b);
    check_bit({tag, "_go_b"}, bfly_go, 1'b0);
    tick();
    bfly_rvalid = 1'b0;
    bfly_result = 8'h00;
    check_b({tag, "_data_a"}, bfly_data, a);
    check_bit({tag, "_go_a"}, bfly_go, 1'b0);
    tick();
    check_b({tag, "_data_wait"}, bfly_data, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] v);
    bfly_rvalid = 1'b1;
    bfly_result = v;
    tick();
    bfly_rvalid = 1'b0;
    bfly_result = 8'h00;
  endtask

  task automatic take_result(input string tag, input logic [15:0] count);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_quiet(tag, count);
    check_bit({tag, "_err_clear"}, res_err, 1'b0);
  endtask

  initial begin
    nReset      = 1'b0;
    job_valid   = 1'b0;
    job_index   = '0;
    job_a       = '0;
    job_b       = '0;
    bfly_result = '0;
    bfly_rvalid = 1'b0;
    res_ready   = 1'b0;

    // Reset held, then released.
    repeat (3) @(posedge Clock);
    #1;
    check_quiet("rst_hold", 16'd0);
    check_result("rst_hold", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    nReset = 1'b1;
    tick();
    check_quiet("rst_rel", 16'd0);

    // Reset asserted after two result bytes: job dropped, nothing emitted.
    send_job("rmid", 3'd1, 8'h10, 8'h20, 1'b0);
    send_byte(8'h12);
    send_byte(8'h34);
    #2 nReset = 1'b0;
    #1;
    check_quiet("rmid", 16'd0);
    check_result("rmid", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    nReset = 1'b1;
    tick();

    // Nominal job with back-to-back result bytes.
    send_job("nom", 3'd5, 8'h20, 8'h40, 1'b0);
    send_byte(8'h3F);
    send_byte(8'hE1);
    send_byte(8'h01);
    check_bit("nom_valid_n7", res_valid, 1'b0);
    send_byte(8'h1F);
    check_bit("nom_valid_n8", res_valid, 1'b1);
    check_bit("nom_out_ready", job_ready, 1'b0);
    check_result("nom", 8'h3F, 8'hE1, 8'h01, 8'h1F, 1'b0);
    check_w("nom_count_pre", job_count, 16'd0);
    take_result("nom_done", 16'd1);

    // Gapped results, stray rvalid in IDLE/SEND_B/OUT, and backpressure.
    send_job("gap", 3'd2, 8'h7F, 8'h80, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check_bit("gap_valid_early", res_valid, 1'b0);
      send_byte(gap_bytes[i]);
      if (i < 3) begin
        tick();
        tick();
      end
    end
    bfly_rvalid = 1'b1;
    bfly_result = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      check_bit("gap_stall_valid", res_valid, 1'b1);
      check_bit("gap_stall_ready", job_ready, 1'b0);
      check_result("gap_stall", 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
      tick();
    end
    bfly_rvalid = 1'b0;
    bfly_result = 8'h00;
    check_result("gap_final", 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    take_result("gap_done", 16'd2);

`ifdef BUTTERFLY_DRIVER_TIMEOUT_EN
    // Only two bytes arrive: eight idle cycles later the result is forced out with res_err.
    send_job("to", 3'd7, 8'h01, 8'h02, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    for (int c = 0; c < 8; c++) begin
      check_bit("to_wait_valid", res_valid, 1'b0);
      check_bit("to_wait_abort", bfly_abort, 1'b0);
      tick();
    end
    check_bit("to_valid", res_valid, 1'b1);
    check_bit("to_abort", bfly_abort, 1'b1);
    check_result("to", 8'h55, 8'h66, 8'h00, 8'h00, 1'b1);
    tick();
    check_bit("to_abort_pulse", bfly_abort, 1'b0);
    check_bit("to_hold_valid", res_valid, 1'b1);
    take_result("to_done", 16'd3);

    send_job("post", 3'd4, 8'hC0, 8'h3C, 1'b0);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    check_bit("post_valid", res_valid, 1'b1);
    check_result("post", 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b0);
    take_result("post_done", 16'd4);
`else
    // Without the timeout a long stall simply waits for the remaining bytes.
    send_job("nto", 3'd7, 8'h01, 8'h02, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    for (int c = 0; c < 20; c++) begin
      check_bit("nto_wait_valid", res_valid, 1'b0);
      check_bit("nto_wait_abort", bfly_abort, 1'b0);
      tick();
    end
    send_byte(8'h77);
    send_byte(8'h88);
    check_bit("nto_valid", res_valid, 1'b1);
    check_result("nto", 8'h55, 8'h66, 8'h77, 8'h88, 1'b0);
    take_result("nto_done", 16'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
